// File: rtl/mem_wb_stage_pkg.sv
// rtl/mem_wb_stage_pkg.sv - shared constants and helpers for the memory/writeback stage
package mem_wb_stage_pkg;

   localparam int TIMEOUT_CYC_DEF = 16;
   localparam int CNT_W           = 8;

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_ACCESS = 1'b1;

   function automatic logic is_misaligned(input logic mem_op, input logic [1:0] addr_lo);
      return mem_op && (addr_lo != 2'b00);
   endfunction

endpackage

// File: rtl/mem_access_fsm.sv
// rtl/mem_access_fsm.sv - data-memory req/ack sequencer with access timeout and pipeline stall
module mem_access_fsm
   import mem_wb_stage_pkg::*;
#(
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
   parameter int ADDR_W      = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              memWr_MEM,
   input  logic              Wrback_MEM,
   input  logic [31:0]       AluResult_MEM,
   input  logic [31:0]       WriteMemData_MEM,
   input  logic              dmem_ack,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [31:0]       dmem_wdata,
   output logic              stall_MEM,
   output logic              acc_idle,
   output logic              acc_done,
   output logic              acc_timeout
);

   logic [0:0]       state;
   logic [CNT_W-1:0] tmo_cnt;
   logic             mem_op;
   logic             start;

   assign mem_op      = memWr_MEM | Wrback_MEM;
   assign acc_idle    = (state == ST_IDLE);
   assign start       = acc_idle && mem_op && !is_misaligned(mem_op, AluResult_MEM[1:0]);
   assign acc_done    = (state == ST_ACCESS) && dmem_ack;
   // An ack on the final allowed cycle still completes the access normally.
   assign acc_timeout = (state == ST_ACCESS) && !dmem_ack &&
                        (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));
   assign stall_MEM   = start || ((state == ST_ACCESS) && !dmem_ack && !acc_timeout);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         tmo_cnt    <= '0;
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_wdata <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state      <= ST_ACCESS;
                  tmo_cnt    <= '0;
                  dmem_req   <= 1'b1;
                  dmem_we    <= memWr_MEM;
                  dmem_addr  <= ADDR_W'(AluResult_MEM);
                  dmem_wdata <= WriteMemData_MEM;
               end
            end
            ST_ACCESS: begin
               if (acc_done || acc_timeout) begin
                  state    <= ST_IDLE;
                  tmo_cnt  <= '0;
                  dmem_req <= 1'b0;
               end else begin
                  tmo_cnt <= tmo_cnt + CNT_W'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - memory-access stage and MEM/WB pipeline register
module mem_wb_stage
   import mem_wb_stage_pkg::*;
#(
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
   parameter int ADDR_W      = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              memWr_MEM,
   input  logic              regWr_MEM,
   input  logic              Wrback_MEM,
   input  logic [31:0]       AluResult_MEM,
   input  logic [31:0]       WriteMemData_MEM,
   input  logic [4:0]        WriteReg_MEM,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [31:0]       dmem_wdata,
   input  logic [31:0]       dmem_rdata,
   input  logic              dmem_ack,
   output logic              stall_MEM,
   output logic              regWr_WB,
   output logic [4:0]        WriteReg_WB,
   output logic [31:0]       WriteData_WB,
   output logic              memErr_WB
);

   logic        acc_idle;
   logic        acc_done;
   logic        acc_timeout;
   logic        mem_op;
   logic        misalign;
   logic        is_load;
   logic        wb_regwr_nxt;
   logic [31:0] wb_data_nxt;
   logic        wb_err_nxt;

   mem_access_fsm #(
      .TIMEOUT_CYC (TIMEOUT_CYC),
      .ADDR_W      (ADDR_W)
   ) u_fsm (
      .clk              (clk),
      .rst              (rst),
      .memWr_MEM        (memWr_MEM),
      .Wrback_MEM       (Wrback_MEM),
      .AluResult_MEM    (AluResult_MEM),
      .WriteMemData_MEM (WriteMemData_MEM),
      .dmem_ack         (dmem_ack),
      .dmem_req         (dmem_req),
      .dmem_we          (dmem_we),
      .dmem_addr        (dmem_addr),
      .dmem_wdata       (dmem_wdata),
      .stall_MEM        (stall_MEM),
      .acc_idle         (acc_idle),
      .acc_done         (acc_done),
      .acc_timeout      (acc_timeout)
   );

   assign mem_op   = memWr_MEM | Wrback_MEM;
   assign misalign = is_misaligned(mem_op, AluResult_MEM[1:0]);
   // A store takes precedence, so a store never writes the register file.
   assign is_load  = Wrback_MEM & ~memWr_MEM;

   always_comb begin
      wb_regwr_nxt = 1'b0;
      wb_data_nxt  = AluResult_MEM;
      wb_err_nxt   = 1'b0;
      if (acc_idle) begin
         if (misalign) begin
            wb_err_nxt = 1'b1;
         end else if (!mem_op) begin
            wb_regwr_nxt = regWr_MEM;
         end
      end else if (acc_done) begin
         wb_regwr_nxt = regWr_MEM & is_load;
         if (is_load) begin
            wb_data_nxt = dmem_rdata;
         end
      end else if (acc_timeout) begin
         wb_err_nxt = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         regWr_WB     <= 1'b0;
         WriteReg_WB  <= '0;
         WriteData_WB <= '0;
         memErr_WB    <= 1'b0;
      end else begin
         regWr_WB     <= wb_regwr_nxt;
         WriteReg_WB  <= WriteReg_MEM;
         WriteData_WB <= wb_data_nxt;
         memErr_WB    <= wb_err_nxt;
      end
   end

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - directed scoreboard bench for mem_wb_stage
module tb_mem_wb_stage;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        memWr_MEM, regWr_MEM, Wrback_MEM;
   logic [31:0] AluResult_MEM, WriteMemData_MEM;
   logic [4:0]  WriteReg_MEM;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic        dmem_ack;
   logic        stall_MEM, regWr_WB, memErr_WB;
   logic [4:0]  WriteReg_WB;
   logic [31:0] WriteData_WB;

   typedef struct {
      logic        rw;
      logic [4:0]  rd;
      logic [31:0] data;
      logic        err;
      logic        chk_data;
   } wb_exp_t;

   wb_exp_t sb_q[$];
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_wb_stage #(.TIMEOUT_CYC(TO), .ADDR_W(32)) dut (
      .clk              (clk),
      .rst              (rst),
      .memWr_MEM        (memWr_MEM),
      .regWr_MEM        (regWr_MEM),
      .Wrback_MEM       (Wrback_MEM),
      .AluResult_MEM    (AluResult_MEM),
      .WriteMemData_MEM (WriteMemData_MEM),
      .WriteReg_MEM     (WriteReg_MEM),
      .dmem_req         (dmem_req),
      .dmem_we          (dmem_we),
      .dmem_addr        (dmem_addr),
      .dmem_wdata       (dmem_wdata),
      .dmem_rdata       (dmem_rdata),
      .dmem_ack         (dmem_ack),
      .stall_MEM        (stall_MEM),
      .regWr_WB         (regWr_WB),
      .WriteReg_WB      (WriteReg_WB),
      .WriteData_WB     (WriteData_WB),
      .memErr_WB        (memErr_WB)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_nop(input logic rw, input logic [4:0] rd, input logic [31:0] alu);
      memWr_MEM        = 1'b0;
      Wrback_MEM       = 1'b0;
      regWr_MEM        = rw;
      WriteReg_MEM     = rd;
      AluResult_MEM    = alu;
      WriteMemData_MEM = '0;
   endtask

   // Called at posedge+1; ack_cyc is the ACCESS cycle (1-based) carrying the ack, 0 = never.
   task automatic run_op(input logic wr, input logic rw, input logic wb,
                         input logic [31:0] alu, input logic [31:0] wdata, input logic [4:0] rd,
                         input int ack_cyc, input logic [31:0] rdata, input string tag);
      logic    mem_op, access, is_load, tmo, done;
      int      exp_st, nst;
      wb_exp_t e;
      mem_op  = wr | wb;
      access  = mem_op && (alu[1:0] == 2'b00);
      is_load = wb & ~wr;
      tmo     = access && (ack_cyc < 1 || ack_cyc > TO);
      exp_st  = !access ? 0 : (tmo ? TO : ack_cyc);
      if (!mem_op)     e = '{rw: rw, rd: rd, data: alu, err: 1'b0, chk_data: 1'b1};
      else if (!access) e = '{rw: 1'b0, rd: rd, data: alu, err: 1'b1, chk_data: 1'b1};
      else if (tmo)    e = '{rw: 1'b0, rd: rd, data: '0, err: 1'b1, chk_data: 1'b0};
      else             e = '{rw: rw & is_load, rd: rd, data: is_load ? rdata : alu,
                             err: 1'b0, chk_data: 1'b1};
      sb_q.push_back(e);

      memWr_MEM = wr; regWr_MEM = rw; Wrback_MEM = wb;
      AluResult_MEM = alu; WriteMemData_MEM = wdata; WriteReg_MEM = rd;
      dmem_rdata = rdata;
      nst = 0;
      done = 1'b0;
      for (int cyc = 0; cyc <= TO + 2 && !done; cyc++) begin
         dmem_ack = (cyc >= 1) && (cyc == ack_cyc);
         #1;
         if (cyc == 0) begin
            check({tag, "/req_idle"}, dmem_req, 1'b0);
         end else begin
            check({tag, "/req"}, dmem_req, 1'b1);
            check({tag, "/we"}, dmem_we, wr);
            check({tag, "/addr"}, dmem_addr, alu);
            check({tag, "/wdata"}, dmem_wdata, wdata);
         end
         if (stall_MEM) nst++;
         else done = 1'b1;
         @(posedge clk);
         #1;
         dmem_ack = 1'b0;
      end
      check({tag, "/retired"}, done, 1'b1);
      check({tag, "/stalls"}, nst, exp_st);
      check({tag, "/req_after"}, dmem_req, 1'b0);

      e = sb_q.pop_front();
      check({tag, "/regWr_WB"}, regWr_WB, e.rw);
      check({tag, "/memErr_WB"}, memErr_WB, e.err);
      if (e.chk_data) check({tag, "/WriteData_WB"}, WriteData_WB, e.data);
      if (e.rw) check({tag, "/WriteReg_WB"}, WriteReg_WB, e.rd);
      set_nop(1'b0, 5'd0, 32'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      rst = 1'b1;
      dmem_ack = 1'b0;
      dmem_rdata = '0;
      set_nop(1'b0, 5'd0, 32'h0);
      @(posedge clk);
      @(posedge clk);
      #1;
      check("rst/dmem_req", dmem_req, 1'b0);
      check("rst/dmem_we", dmem_we, 1'b0);
      check("rst/dmem_addr", dmem_addr, 32'h0);
      check("rst/dmem_wdata", dmem_wdata, 32'h0);
      check("rst/regWr_WB", regWr_WB, 1'b0);
      check("rst/WriteReg_WB", WriteReg_WB, 5'd0);
      check("rst/WriteData_WB", WriteData_WB, 32'h0);
      check("rst/memErr_WB", memErr_WB, 1'b0);
      check("rst/stall_MEM", stall_MEM, 1'b0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      run_op(1'b0, 1'b1, 1'b0, 32'h0000_1234, 32'h0, 5'd5, 0, 32'h0, "nonmem");
      run_op(1'b0, 1'b1, 1'b1, 32'h0000_0100, 32'h0, 5'd3, 4, 32'hDEAD_BEEF, "load_slow");
      run_op(1'b1, 1'b1, 1'b0, 32'h0000_0040, 32'hA5A5_A5A5, 5'd9, 1, 32'h1111_1111, "store");
      run_op(1'b0, 1'b1, 1'b1, 32'h0000_0102, 32'h0, 5'd4, 0, 32'h0, "misalign");
      run_op(1'b0, 1'b1, 1'b1, 32'h0000_0200, 32'h0, 5'd6, 0, 32'h2222_2222, "timeout");

      // late ack after the timeout must be ignored
      set_nop(1'b1, 5'd7, 32'h0000_0077);
      dmem_ack = 1'b1;
      #1;
      check("late_ack/stall", stall_MEM, 1'b0);
      @(posedge clk);
      #1;
      dmem_ack = 1'b0;
      check("late_ack/req", dmem_req, 1'b0);
      check("late_ack/regWr_WB", regWr_WB, 1'b1);
      check("late_ack/WriteData_WB", WriteData_WB, 32'h0000_0077);
      check("late_ack/memErr_WB", memErr_WB, 1'b0);
      set_nop(1'b0, 5'd0, 32'h0);

      run_op(1'b0, 1'b1, 1'b1, 32'h0000_03FC, 32'h0, 5'd10, 2, 32'h0BAD_F00D, "load_fast");
      run_op(1'b1, 1'b0, 1'b1, 32'h0000_0010, 32'h5A5A_0001, 5'd11, 3, 32'h3333_3333, "store_wb");

      // async reset in the middle of an access
      memWr_MEM = 1'b0; Wrback_MEM = 1'b1; regWr_MEM = 1'b1;
      AluResult_MEM = 32'h0000_0080; WriteReg_MEM = 5'd12;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      check("rst_mid/req_before", dmem_req, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      check("rst_mid/dmem_req", dmem_req, 1'b0);
      check("rst_mid/regWr_WB", regWr_WB, 1'b0);
      check("rst_mid/WriteReg_WB", WriteReg_WB, 5'd0);
      check("rst_mid/WriteData_WB", WriteData_WB, 32'h0);
      check("rst_mid/memErr_WB", memErr_WB, 1'b0);
      set_nop(1'b0, 5'd0, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      run_op(1'b0, 1'b1, 1'b0, 32'h0000_CAFE, 32'h0, 5'd1, 0, 32'h0, "after_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
